shift18_seq: RTL and testbench
==============================

# shift18_seq

Request sequencer that sits directly upstream of the 64-bit shift18 register and drives its `load`, `ena`, `amount` and `data` inputs. It accepts one shift request at a time through a valid/ready handshake. Each request carries a 64-bit operand, a 6-bit shift count and a direction. The block breaks the count into ±8 and ±1 steps, issues those steps to the shifter, and returns the shifter's `q` through a valid/ready response port.

## Interface
Parameters:
- none (width fixed at 64, count fixed at 6 bits)

Ports:
- clk  in  1  rising-edge clock shared with the shifter
- rst_n  in  1  reset; one clock, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_data  in  64  operand to load
- req_count  in  6  shift distance, 0..63
- req_dir  in  1  0 = left logical, 1 = right arithmetic
- sh_load  out  1  to shifter `load`
- sh_ena  out  1  to shifter `ena`
- sh_amount  out  2  to shifter `amount`
- sh_data  out  64  to shifter `data`
- sh_q  in  64  from shifter `q`
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  64  result (equal to sh_q while rsp_valid is high)

## Operation
- States: IDLE, LOAD, SHIFT, DONE. The state register and all internal registers are updated on clk.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture operand into sh_data register, count into `remaining`, and direction. Next state is LOAD.
- LOAD:
  - sh_load=1 and sh_ena=0.
  - Next state is SHIFT if remaining≠0, otherwise DONE.
- SHIFT:
  - sh_ena=1.
  - If remaining≥8: sh_amount = 01 for left, 11 for right; remaining −= 8.
  - Otherwise: sh_amount = 00 for left, 10 for right; remaining −= 1.
  - Go to DONE in the same cycle that remaining is decremented to 0.
- DONE:
  - rsp_valid=1, rsp_data=sh_q; all sh_* controls are 0, so the shifter holds its value.
  - On rsp_ready, go to IDLE.
- Step count: N = count[5:3] + count[2:0]. For count=63, N=14.
- Outside LOAD and SHIFT: sh_load=0, sh_ena=0, sh_amount=00. sh_data holds the last captured operand.
- A new request is not accepted until the DONE→IDLE transition. There is no overlap between requests.
- Reset values: state=IDLE, remaining=0, sh_data=0, direction=0. Resulting outputs: req_ready=1, rsp_valid=0, sh_load=0, sh_ena=0, sh_amount=00.
- Reset asserted mid-operation (LOAD, SHIFT or DONE): the next state is IDLE and the in-flight request is dropped with no response. The contents of sh_q are then don't-care.

## Timing
- Accept edge = T.
- sh_load is high during cycle T+1.
- SHIFT occupies cycles T+2 .. T+1+N.
- rsp_valid rises at T+2+N. For count=0, rsp_valid rises at T+2.
- Back-to-back throughput: N+3 cycles per request when rsp_ready is held high.
- rsp_valid and rsp_data stay stable until the rsp_ready handshake.
- req_ready is low from T+1 until the cycle after the response handshake.
- All sh_* outputs are Moore outputs: they are decoded from state, `remaining` and direction only, with no combinational path from req_* or rsp_ready.

## Configuration
- SHIFT18_SEQ_STATS_EN:
  - Defined: adds output port `stat_ops` (32 bits). Reset value 0. Increments on every rsp_valid&&rsp_ready and saturates at 0xFFFF_FFFF.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `shift18_seq_pkg`:
  - State enum typedef.
  - Amount encodings SH_L1=2'b00, SH_L8=2'b01, SH_R1=2'b10, SH_R8=2'b11.
  - Constants DATA_W=64 and CNT_W=6.
- One sub-module, `shift18_step_sel`, is natural: it is combinational and takes remaining and direction, returning sh_amount and the next remaining value.

## Test plan
- data=0x1, count=9, dir=0 → sh_amount sequence 01, 00; rsp_data=0x0000_0000_0000_0200; rsp_valid at T+4.
- data=0x8000_0000_0000_0000, count=63, dir=1 → 14 SHIFT cycles; rsp_data=0xFFFF_FFFF_FFFF_FFFF; rsp_valid at T+16.
- data=0x1234_5678_9ABC_DEF0, count=0 → sh_ena never asserted; rsp_data equals the input; rsp_valid at T+2.
- rsp_ready held low for 5 cycles in DONE → rsp_valid and rsp_data stable, req_ready=0, sh_load=sh_ena=0 throughout.
- rst_n=0 for one cycle during SHIFT (count=20) → next cycle req_ready=1, rsp_valid=0, sh_ena=0. A follow-up request with data=0xFF, count=8, dir=0 returns 0xFF00.
- With SHIFT18_SEQ_STATS_EN: three completed requests → stat_ops=3. A request aborted by reset does not increment stat_ops.

Source files
------------

// File: rtl/shift18_seq_pkg.sv
// Shared types and constants for the shift18 request sequencer.
package shift18_seq_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 6;

  localparam logic [1:0] SH_L1 = 2'b00;
  localparam logic [1:0] SH_L8 = 2'b01;
  localparam logic [1:0] SH_R1 = 2'b10;
  localparam logic [1:0] SH_R8 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shift18_step_sel.sv
// Picks the next shifter step (by 8 or by 1) from the remaining distance and direction.
module shift18_step_sel
  import shift18_seq_pkg::*;
(
  input  logic [CNT_W-1:0] remaining,
  input  logic             dir,
  output logic [1:0]       amount,
  output logic [CNT_W-1:0] remaining_next
);

  always_comb begin
    if (remaining >= CNT_W'(8)) begin
      amount         = dir ? SH_R8 : SH_L8;
      remaining_next = remaining - CNT_W'(8);
    end else begin
      amount         = dir ? SH_R1 : SH_L1;
      remaining_next = remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift18_seq.sv
// Request sequencer driving the shift18 register: load, then +/-8 and +/-1 steps, then respond.
// Optional SHIFT18_SEQ_STATS_EN adds a saturating completed-request counter on stat_ops.
module shift18_seq
  import shift18_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [CNT_W-1:0]  req_count,
  input  logic              req_dir,
  output logic              sh_load,
  output logic              sh_ena,
  output logic [1:0]        sh_amount,
  output logic [DATA_W-1:0] sh_data,
  input  logic [DATA_W-1:0] sh_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef SHIFT18_SEQ_STATS_EN
  output logic [31:0]       stat_ops,
`endif
  output logic [DATA_W-1:0] rsp_data
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dir_q, dir_d;
  logic [1:0]         step_amount;
  logic [CNT_W-1:0]   step_next;

  shift18_step_sel u_step_sel (
    .remaining      (remaining_q),
    .dir            (dir_q),
    .amount         (step_amount),
    .remaining_next (step_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      data_q      <= '0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    dir_d       = dir_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    sh_load     = 1'b0;
    sh_ena      = 1'b0;
    sh_amount   = SH_L1;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          data_d      = req_data;
          remaining_d = req_count;
          dir_d       = req_dir;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        sh_load = 1'b1;
        state_d = (remaining_q != '0) ? StShift : StDone;
      end
      StShift: begin
        sh_ena      = 1'b1;
        sh_amount   = step_amount;
        remaining_d = step_next;
        if (step_next == '0) state_d = StDone;
      end
      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sh_data  = data_q;
  assign rsp_data = sh_q;

`ifdef SHIFT18_SEQ_STATS_EN
  logic [31:0] stat_ops_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
    end else if (rsp_valid && rsp_ready && (stat_ops_q != 32'hFFFF_FFFF)) begin
      stat_ops_q <= stat_ops_q + 32'd1;
    end
  end

  assign stat_ops = stat_ops_q;
`endif

endmodule

// File: tb/tb_shift18_seq.sv
// Directed bench for shift18_seq with a behavioural shift18 register on the sh_* side.
module tb_shift18_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_data;
  logic [5:0]  req_count;
  logic        req_dir;
  logic        sh_load;
  logic        sh_ena;
  logic [1:0]  sh_amount;
  logic [63:0] sh_data;
  logic [63:0] sh_q;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
`ifdef SHIFT18_SEQ_STATS_EN
  logic [31:0] stat_ops;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  shift18_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_count (req_count),
    .req_dir   (req_dir),
    .sh_load   (sh_load),
    .sh_ena    (sh_ena),
    .sh_amount (sh_amount),
    .sh_data   (sh_data),
    .sh_q      (sh_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
`ifdef SHIFT18_SEQ_STATS_EN
    .stat_ops  (stat_ops),
`endif
    .rsp_data  (rsp_data)
  );

  // Shift18 register: 00 <<1, 01 <<8, 10 >>>1, 11 >>>8.
  always_ff @(posedge clk) begin
    if (sh_load) begin
      sh_q <= sh_data;
    end else if (sh_ena) begin
      case (sh_amount)
        2'b00:   sh_q <= sh_q << 1;
        2'b01:   sh_q <= sh_q << 8;
        2'b10:   sh_q <= {sh_q[63], sh_q[63:1]};
        default: sh_q <= {{8{sh_q[63]}}, sh_q[63:8]};
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; check load pulse, step mix, latency and result; optionally complete it.
  task automatic run_req(input string tag, input logic [63:0] d, input logic [5:0] c,
                         input logic dir, input logic [63:0] exp_q, input int exp_lat,
                         input int exp_n8, input int exp_n1, input logic [1:0] exp_first,
                         input bit release_rsp);
    int k;
    int n8;
    int n1;
    logic [1:0] first;
    n8 = 0;
    n1 = 0;
    first = 2'bxx;
    req_valid = 1'b1;
    req_data  = d;
    req_count = c;
    req_dir   = dir;
    step();
    req_valid = 1'b0;
    k = 1;
    check({tag, "_load"}, 64'(sh_load), 64'd1);
    check({tag, "_busy"}, 64'(req_ready), 64'd0);
    while (!rsp_valid && k < 40) begin
      step();
      k++;
      if (sh_ena) begin
        if (n8 + n1 == 0) first = sh_amount;
        if (sh_amount[0]) n8++;
        else n1++;
      end
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check({tag, "_data"}, rsp_data, exp_q);
    check({tag, "_n8"}, 64'(n8), 64'(exp_n8));
    check({tag, "_n1"}, 64'(n1), 64'(exp_n1));
    if (n8 + n1 > 0) check({tag, "_first"}, 64'(first), 64'(exp_first));
    if (release_rsp) begin
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_done++;
      check({tag, "_rspdrop"}, 64'(rsp_valid), 64'd0);
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_count = '0;
    req_dir   = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_sh_load", 64'(sh_load), 64'd0);
    check("rst_sh_ena", 64'(sh_ena), 64'd0);
    check("rst_sh_amount", 64'(sh_amount), 64'd0);
    check("rst_sh_data", sh_data, 64'd0);
    rst_n = 1'b1;
    step();

    run_req("l9", 64'h1, 6'd9, 1'b0, 64'h0000_0000_0000_0200, 4, 1, 1, 2'b01, 1'b1);
    run_req("r63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16, 7, 7,
            2'b11, 1'b1);
    run_req("c0", 64'h1234_5678_9ABC_DEF0, 6'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 2, 0, 0,
            2'b00, 1'b1);
    run_req("r4", 64'h0000_0000_0000_0F00, 6'd4, 1'b1, 64'h0000_0000_0000_00F0, 6, 0, 4,
            2'b10, 1'b1);

    // Response back-pressure: hold rsp_ready low for five DONE cycles.
    run_req("stall", 64'h5, 6'd3, 1'b0, 64'h28, 5, 0, 3, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_data", rsp_data, 64'h28);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_ctrl", 64'({sh_load, sh_ena}), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_done++;
    check("stall_ready", 64'(req_ready), 64'd1);

    // Reset during SHIFT drops the request.
    req_valid = 1'b1;
    req_data  = 64'hDEAD_BEEF;
    req_count = 6'd20;
    req_dir   = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    check("abort_in_shift", 64'(sh_ena), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_sh_ena", 64'(sh_ena), 64'd0);
    run_req("post", 64'hFF, 6'd8, 1'b0, 64'hFF00, 3, 1, 0, 2'b01, 1'b1);

`ifdef SHIFT18_SEQ_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(n_done));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
